// File: rtl/missile_pool.sv
// missile_pool: pool of concurrent player missiles.
// Handles launch cooldown, per-frame upward motion, top-of-screen retirement,
// external hit kills and a registered draw request for the video priority mux.
module missile_pool #(
    parameter int                       NUM_MISSILES    = 4,
    parameter int                       PIXEL_WIDTH     = 11,
    parameter int                       RGB_WIDTH       = 8,
    parameter int                       MISSILE_W       = 4,
    parameter int                       MISSILE_H       = 8,
    parameter int                       SPEED           = 4,
    parameter int                       COOLDOWN_FRAMES = 8,
    parameter int                       TOP_LIMIT       = 0,
    parameter logic [RGB_WIDTH-1:0]     MISSILE_RGB     = 8'hFC,
    localparam int                      IDX_W           = (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fire,
    input  logic                          startOfFrame,
    input  logic signed [PIXEL_WIDTH-1:0] spawn_x,
    input  logic signed [PIXEL_WIDTH-1:0] spawn_y,
    input  logic [PIXEL_WIDTH-1:0]        pixelX,
    input  logic [PIXEL_WIDTH-1:0]        pixelY,
    input  logic [NUM_MISSILES-1:0]       hit_clear,
    output logic                          missileDR,
    output logic [RGB_WIDTH-1:0]          missileRGB,
    output logic [IDX_W-1:0]              draw_idx,
    output logic [NUM_MISSILES-1:0]       active_mask
);

    // Cooldown counter wide enough to hold COOLDOWN_FRAMES.
    localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    // Extended width for hit tests: room for sign, zero-extended pixel and x+W.
    localparam int EW   = PIXEL_WIDTH + 2;

    logic [NUM_MISSILES-1:0]       active_r;
    logic signed [PIXEL_WIDTH-1:0] x_r [NUM_MISSILES];
    logic signed [PIXEL_WIDTH-1:0] y_r [NUM_MISSILES];
    logic [CD_W-1:0]               cooldown_r;

    logic                          free_found_s;
    logic [IDX_W-1:0]              free_idx_s;
    logic                          launch_s;
    logic signed [PIXEL_WIDTH:0]   y_next_s [NUM_MISSILES];
    logic [NUM_MISSILES-1:0]       hit_s;
    logic [IDX_W-1:0]              hit_idx_s;

    assign active_mask = active_r;

    // Lowest-index slot that is free at the start of this cycle.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int i = NUM_MISSILES - 1; i >= 0; i--) begin
            if (!active_r[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // A launch happens only on a frame pulse with fire held, cooldown expired and a free slot.
    always_comb begin
        if (startOfFrame && fire && (cooldown_r == '0) && free_found_s) begin
            launch_s = 1'b1;
        end else begin
            launch_s = 1'b0;
        end
    end

    // Candidate new y per slot, one bit wider so moving past the top edge cannot wrap.
    always_comb begin
        for (int i = 0; i < NUM_MISSILES; i++) begin
            y_next_s[i] = (PIXEL_WIDTH + 1)'(y_r[i]) - $signed((PIXEL_WIDTH + 1)'(SPEED));
        end
    end

    // Per-slot pixel hit test using signed compares against the zero-extended scan position.
    always_comb begin
        logic signed [EW-1:0] px_e;
        logic signed [EW-1:0] py_e;
        logic signed [EW-1:0] x_e;
        logic signed [EW-1:0] y_e;
        px_e = $signed({2'b00, pixelX});
        py_e = $signed({2'b00, pixelY});
        hit_s = '0;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            x_e = EW'(x_r[i]);
            y_e = EW'(y_r[i]);
            hit_s[i] = active_r[i]
                    && (x_e <= px_e) && (px_e < x_e + $signed(EW'(MISSILE_W)))
                    && (y_e <= py_e) && (py_e < y_e + $signed(EW'(MISSILE_H)));
        end
    end

    // Lowest-index slot covering the current pixel (0 when none).
    always_comb begin
        hit_idx_s = '0;
        for (int i = NUM_MISSILES - 1; i >= 0; i--) begin
            if (hit_s[i]) begin
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // Slot state: kill beats launch/move; movement and retirement only on frame pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_r <= '0;
            for (int i = 0; i < NUM_MISSILES; i++) begin
                x_r[i] <= '0;
                y_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MISSILES; i++) begin
                if (hit_clear[i]) begin
                    active_r[i] <= 1'b0;
                end else if (launch_s && (free_idx_s == IDX_W'(i))) begin
                    active_r[i] <= 1'b1;
                    x_r[i]      <= spawn_x;
                    y_r[i]      <= spawn_y;
                end else if (startOfFrame && active_r[i]) begin
                    if (y_next_s[i] < $signed((PIXEL_WIDTH + 1)'(TOP_LIMIT))) begin
                        active_r[i] <= 1'b0;
                    end else begin
                        y_r[i] <= y_next_s[i][PIXEL_WIDTH-1:0];
                    end
                end
            end
        end
    end

    // Launch cooldown: reload on launch, otherwise saturating per-frame decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            cooldown_r <= '0;
        end else if (launch_s) begin
            cooldown_r <= CD_W'(COOLDOWN_FRAMES);
        end else if (startOfFrame && (cooldown_r != '0)) begin
            cooldown_r <= cooldown_r - CD_W'(1);
        end
    end

    // Registered draw outputs, computed from slot state before this edge's update.
    always_ff @(posedge clk) begin
        if (reset) begin
            missileDR  <= 1'b0;
            missileRGB <= '0;
            draw_idx   <= '0;
        end else begin
            missileDR  <= |hit_s;
            missileRGB <= (|hit_s) ? MISSILE_RGB : '0;
            draw_idx   <= hit_idx_s;
        end
    end

endmodule
